// File: rtl/dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module   : dead_time_gen
// Purpose  : Complementary high/low gate drive from one PWM demand bit, with
//            programmable dead time and a latched fault. The optional minimum
//            on-time hold is enabled by defining DTG_MIN_ON_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dead_time_gen #(
    parameter int DT_WIDTH = 4,
    parameter int MIN_ON   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic                gate_hs,
    output logic                gate_ls,
    output logic                dt_active,
    output logic                fault_latched
);

    localparam logic [2:0] c_OFF   = 3'd0;
    localparam logic [2:0] c_DT_HS = 3'd1;
    localparam logic [2:0] c_HS_ON = 3'd2;
    localparam logic [2:0] c_DT_LS = 3'd3;
    localparam logic [2:0] c_LS_ON = 3'd4;
    localparam logic [2:0] c_FAULT = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_stateNext;
    logic [DT_WIDTH-1:0] r_dtCnt;
    logic                w_dtLoad;
    logic                w_minOnDone;
    logic                r_gateHs;
    logic                r_gateLs;
    logic                r_dtActive;
    logic                r_faultLatched;

`ifdef DTG_MIN_ON_EN
    localparam int c_MO_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;

    logic [c_MO_W-1:0] r_minCnt;

    // Loads on entry to an on-state; a demand reversal waits until it is zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_minCnt <= '0;
        end else if ((w_stateNext == c_HS_ON && r_state != c_HS_ON) ||
                     (w_stateNext == c_LS_ON && r_state != c_LS_ON)) begin
            r_minCnt <= c_MO_W'(MIN_ON - 1);
        end else if (r_minCnt != '0) begin
            r_minCnt <= r_minCnt - 1'b1;
        end
    end

    assign w_minOnDone = (r_minCnt == '0);
`else
    // No hold in this build; MIN_ON is only referenced so it stays in the interface.
    assign w_minOnDone = 1'b1 | MIN_ON[0];
`endif

    always_comb begin
        w_stateNext = c_OFF;
        w_dtLoad    = 1'b0;
        if (r_state == c_FAULT) begin
            w_stateNext = (fault_clr && !fault_in) ? c_OFF : c_FAULT;
        end else if (fault_in) begin
            w_stateNext = c_FAULT;
        end else if (!enable) begin
            w_stateNext = c_OFF;
        end else begin
            case (r_state)
                c_OFF: begin
                    w_dtLoad    = 1'b1;
                    w_stateNext = pwm_in ? c_DT_HS : c_DT_LS;
                end
                c_DT_HS: begin
                    if (!pwm_in) begin
                        w_dtLoad    = 1'b1;
                        w_stateNext = c_DT_LS;
                    end else begin
                        w_stateNext = (r_dtCnt == '0) ? c_HS_ON : c_DT_HS;
                    end
                end
                c_DT_LS: begin
                    if (pwm_in) begin
                        w_dtLoad    = 1'b1;
                        w_stateNext = c_DT_HS;
                    end else begin
                        w_stateNext = (r_dtCnt == '0) ? c_LS_ON : c_DT_LS;
                    end
                end
                c_HS_ON: begin
                    if (!pwm_in && w_minOnDone) begin
                        w_dtLoad    = 1'b1;
                        w_stateNext = c_DT_LS;
                    end else begin
                        w_stateNext = c_HS_ON;
                    end
                end
                c_LS_ON: begin
                    if (pwm_in && w_minOnDone) begin
                        w_dtLoad    = 1'b1;
                        w_stateNext = c_DT_HS;
                    end else begin
                        w_stateNext = c_LS_ON;
                    end
                end
                default: w_stateNext = c_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_OFF;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counts down only while dwelling in a dead-time state and parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dtCnt <= '0;
        end else if (w_dtLoad) begin
            r_dtCnt <= dead_time;
        end else if ((r_state == c_DT_HS || r_state == c_DT_LS) && r_dtCnt != '0) begin
            r_dtCnt <= r_dtCnt - 1'b1;
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gateHs       <= 1'b0;
            r_gateLs       <= 1'b0;
            r_dtActive     <= 1'b0;
            r_faultLatched <= 1'b0;
        end else begin
            r_gateHs       <= (w_stateNext == c_HS_ON);
            r_gateLs       <= (w_stateNext == c_LS_ON);
            r_dtActive     <= (w_stateNext == c_DT_HS) || (w_stateNext == c_DT_LS);
            r_faultLatched <= (w_stateNext == c_FAULT);
        end
    end

    assign gate_hs       = r_gateHs;
    assign gate_ls       = r_gateLs;
    assign dt_active     = r_dtActive;
    assign fault_latched = r_faultLatched;

endmodule
`default_nettype wire

// File: tb/tb_dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dead_time_gen
// Purpose  : Directed and randomized checks of dead_time_gen against a
//            cycle-level behavioural model of gate ownership.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dead_time_gen;

    localparam int DT_WIDTH = 4;
    localparam int MIN_ON   = 4;

    localparam int c_M_OFF   = 0;
    localparam int c_M_DEAD  = 1;
    localparam int c_M_ON    = 2;
    localparam int c_M_FAULT = 3;

`ifdef DTG_MIN_ON_EN
    localparam int c_MIN_ON_REQ = MIN_ON;
`else
    localparam int c_MIN_ON_REQ = 1;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_time;
    logic                fault_in;
    logic                fault_clr;
    logic                gate_hs;
    logic                gate_ls;
    logic                dt_active;
    logic                fault_latched;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the bridge, and how long the dead gap / on-time has run.
    int mMode     = c_M_OFF;
    bit mSide     = 1'b0;
    int mNeed     = 0;
    int mElapsed  = 0;
    int mOnCycles = 0;

    dead_time_gen #(
        .DT_WIDTH (DT_WIDTH),
        .MIN_ON   (MIN_ON)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .gate_hs       (gate_hs),
        .gate_ls       (gate_ls),
        .dt_active     (dt_active),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic startDead(input bit side);
        mMode    = c_M_DEAD;
        mSide    = side;
        mNeed    = int'(dead_time) + 1;
        mElapsed = 1;
    endtask

    task automatic modelStep();
        if (reset) begin
            mMode = c_M_OFF;
        end else if (mMode == c_M_FAULT) begin
            if (fault_clr && !fault_in) mMode = c_M_OFF;
        end else if (fault_in) begin
            mMode = c_M_FAULT;
        end else if (!enable) begin
            mMode = c_M_OFF;
        end else if (mMode == c_M_OFF) begin
            startDead(pwm_in);
        end else if (mMode == c_M_DEAD) begin
            if (pwm_in != mSide) begin
                startDead(pwm_in);
            end else if (mElapsed == mNeed) begin
                mMode     = c_M_ON;
                mOnCycles = 1;
            end else begin
                mElapsed++;
            end
        end else begin
            if (pwm_in != mSide && mOnCycles >= c_MIN_ON_REQ) startDead(pwm_in);
            else mOnCycles++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkValue("gate_hs", gate_hs, (mMode == c_M_ON && mSide) ? 1 : 0);
        checkValue("gate_ls", gate_ls, (mMode == c_M_ON && !mSide) ? 1 : 0);
        checkValue("dt_active", dt_active, (mMode == c_M_DEAD) ? 1 : 0);
        checkValue("fault_latched", fault_latched, (mMode == c_M_FAULT) ? 1 : 0);
        checkValue("overlap", gate_hs & gate_ls, 0);
    endtask

    task automatic waitGate(input bit hs);
        int n;
        n = 0;
        while (((hs ? gate_hs : gate_ls) !== 1'b1) && n < 64) begin
            tick();
            n++;
        end
        if ((hs ? gate_hs : gate_ls) !== 1'b1) checkValue("wait_gate_timeout", 0, 1);
    endtask

    initial begin
        int cnt;
        bit hsSeen;

        // Reset held with demand active.
        reset = 1'b1; enable = 1'b1; pwm_in = 1'b1;
        dead_time = '0; fault_in = 1'b0; fault_clr = 1'b0;
        tick();
        tick();
        checkValue("reset_hs", gate_hs, 0);
        checkValue("reset_ls", gate_ls, 0);
        checkValue("reset_dt", dt_active, 0);
        checkValue("reset_fault", fault_latched, 0);
        reset = 1'b0;

        // dead_time=3: four both-low cycles in each direction.
        dead_time = 4'd3; pwm_in = 1'b0;
        waitGate(1'b0);
        pwm_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && gate_hs !== 1'b1; i++) begin
            tick();
            if (!gate_hs && !gate_ls) cnt++;
        end
        checkValue("dt3_ls_to_hs_low", cnt, 4);
        pwm_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && gate_ls !== 1'b1; i++) begin
            tick();
            if (!gate_hs && !gate_ls) cnt++;
        end
        checkValue("dt3_hs_to_ls_low", cnt, 4);

        // dead_time=0: one both-low cycle per transition.
        dead_time = 4'd0;
        for (int t = 0; t < 4; t++) begin
            pwm_in = ~pwm_in;
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (!gate_hs && !gate_ls) cnt++;
            end
            checkValue("dt0_low_count", cnt, 1);
        end

        // dead_time=5 with a reversal two cycles into the gap.
        dead_time = 4'd5; pwm_in = 1'b0;
        waitGate(1'b0);
        pwm_in = 1'b1;
        tick();
        tick();
        pwm_in = 1'b0;
        tick();
        hsSeen = gate_hs;
        cnt = 0;
        while (gate_ls !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
            if (gate_hs) hsSeen = 1'b1;
        end
        checkValue("abort_hs_never", hsSeen, 0);
        checkValue("abort_ls_delay", cnt, 6);

        // Fault latch and clear handshake.
        dead_time = 4'd2; pwm_in = 1'b1;
        waitGate(1'b1);
        fault_in = 1'b1;
        tick();
        checkValue("fault_set", fault_latched, 1);
        checkValue("fault_hs_off", gate_hs, 0);
        fault_in = 1'b0;
        tick();
        fault_in = 1'b1; fault_clr = 1'b1;
        tick();
        checkValue("fault_clr_ignored", fault_latched, 1);
        fault_in = 1'b0; fault_clr = 1'b0;
        tick();
        checkValue("fault_held", fault_latched, 1);
        fault_clr = 1'b1;
        tick();
        checkValue("fault_cleared", fault_latched, 0);
        fault_clr = 1'b0;
        tick();
        checkValue("fault_restart_dt", dt_active, 1);
        waitGate(1'b1);

`ifdef DTG_MIN_ON_EN
        // Single-cycle reversal after high side turns on: held MIN_ON cycles.
        dead_time = 4'd0; pwm_in = 1'b0;
        waitGate(1'b0);
        pwm_in = 1'b1;
        waitGate(1'b1);
        pwm_in = 1'b0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gate_hs) cnt++;
        end
        checkValue("min_on_hold", cnt, MIN_ON);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 39) != 0);
            fault_in  = ($urandom_range(0, 59) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(0, 9) == 0) dead_time = DT_WIDTH'($urandom_range(0, (1 << DT_WIDTH) - 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
